// File: rtl/uart_pixel_feeder_pkg.sv
// Shared constants for the UART pixel feeder and the TFT timing controller it serves.
// Holds the display geometry, framing byte, underflow colour and byte-FSM encoding.
package uart_pixel_feeder_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = 16;

    localparam logic [7:0]       DEF_SYNC_BYTE   = 8'hA5;
    localparam logic [PIX_W-1:0] DEF_UNDER_COLOR = 16'hF81F;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        HI_BYTE   = 2'd1,
        LO_BYTE   = 2'd2
    } byte_state_t;

endpackage

// File: rtl/uart_pixel_feeder_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is readable without a pop.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16
) (
    input  logic                     CLK_33M,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK_33M) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK_33M) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_pixel_feeder.sv
// Builds RGB565 pixels from framed UART bytes and feeds them to the TFT controller
// through a FWFT FIFO, raising Data_start once enough pixels are buffered.
//
//  state     | meaning
//  WAIT_SYNC | hunting for the frame header byte; other bytes are discarded
//  HI_BYTE   | next byte is pixel[15:8]
//  LO_BYTE   | next byte is pixel[7:0]; completes and pushes the pixel
module uart_pixel_feeder
    import uart_pixel_feeder_pkg::*;
#(
    parameter int               FIFO_DEPTH   = 1024,
    parameter int               START_LEVEL  = 512,
    parameter int               FRAME_PIXELS = 384000,
    parameter logic [7:0]       SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter logic [PIX_W-1:0] UNDER_COLOR  = DEF_UNDER_COLOR
) (
    input  logic                         CLK_33M,
    input  logic                         Reset,
    input  logic [7:0]                   Rx_data,
    input  logic                         Rx_done,
    input  logic                         Data_req,
    output logic [PIX_W-1:0]             Data_in,
    output logic                         Data_start,
    output logic [$clog2(FIFO_DEPTH):0]  Fifo_level,
    output logic                         Frame_done,
    output logic                         Overflow,
    output logic                         Underflow
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    byte_state_t      state;
    logic [7:0]       hi_q;
    logic [CW-1:0]    pix_cnt;
    logic             push_q;
    logic [PIX_W-1:0] push_pix;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PIX_W-1:0] fifo_head;
    logic             pop;

    assign pop     = Data_req && !fifo_empty;
    assign Data_in = fifo_empty ? UNDER_COLOR : fifo_head;

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .CLK_33M (CLK_33M),
        .Reset   (Reset),
        .push    (push_q),
        .wdata   (push_pix),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (Fifo_level),
        .head    (fifo_head)
    );

    always_ff @(posedge CLK_33M) begin
        if (Reset) begin
            state      <= WAIT_SYNC;
            hi_q       <= '0;
            pix_cnt    <= '0;
            push_q     <= 1'b0;
            push_pix   <= '0;
            Frame_done <= 1'b0;
            Data_start <= 1'b0;
            Overflow   <= 1'b0;
            Underflow  <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            Frame_done <= 1'b0;
            if (Rx_done) begin
                case (state)
                    WAIT_SYNC: begin
                        if (Rx_data == SYNC_BYTE)
                            state <= HI_BYTE;
                    end
                    HI_BYTE: begin
                        hi_q  <= Rx_data;
                        state <= LO_BYTE;
                    end
                    LO_BYTE: begin
                        push_q   <= 1'b1;
                        push_pix <= {hi_q, Rx_data};
                        // Counter advances even if the FIFO later drops this pixel.
                        if (pix_cnt == CW'(FRAME_PIXELS - 1)) begin
                            Frame_done <= 1'b1;
                            pix_cnt    <= '0;
                            state      <= WAIT_SYNC;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                            state   <= HI_BYTE;
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
            if (push_q && fifo_full && !pop)
                Overflow <= 1'b1;
            if (Data_req && fifo_empty)
                Underflow <= 1'b1;
            if (Fifo_level >= LW'(START_LEVEL))
                Data_start <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_pixel_feeder.sv
// Bench for uart_pixel_feeder: directed scenarios plus random traffic against a
// queue-based reference model of the byte framing and FIFO behaviour.
module tb_uart_pixel_feeder;

    localparam int          DEPTH = 4;
    localparam int          START = 3;
    localparam int          FRAME = 4;
    localparam logic [15:0] UC    = 16'hF81F;

    logic        CLK_33M  = 1'b0;
    logic        Reset    = 1'b1;
    logic [7:0]  Rx_data  = 8'h00;
    logic        Rx_done  = 1'b0;
    logic        Data_req = 1'b0;
    logic [15:0] Data_in;
    logic        Data_start;
    logic [2:0]  Fifo_level;
    logic        Frame_done;
    logic        Overflow;
    logic        Underflow;

    uart_pixel_feeder #(
        .FIFO_DEPTH   (DEPTH),
        .START_LEVEL  (START),
        .FRAME_PIXELS (FRAME)
    ) dut (
        .CLK_33M    (CLK_33M),
        .Reset      (Reset),
        .Rx_data    (Rx_data),
        .Rx_done    (Rx_done),
        .Data_req   (Data_req),
        .Data_in    (Data_in),
        .Data_start (Data_start),
        .Fifo_level (Fifo_level),
        .Frame_done (Frame_done),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    always #5 CLK_33M = ~CLK_33M;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_seen = 0;

    // Reference model: byte stream parser, one-cycle push delay, pixel queue.
    logic [15:0] mq[$];
    bit          m_pend = 0;
    logic [15:0] m_pend_pix = '0;
    bit          m_hunt = 1;
    bit          m_have_hi = 0;
    logic [7:0]  m_hi = '0;
    int          m_cnt = 0;
    bit          m_fd = 0;
    bit          m_ds = 0;
    bit          m_ov = 0;
    bit          m_uf = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit rv, input logic [7:0] rb, input bit rq);
        int  size0;
        bit  popped;
        if (rst) begin
            mq.delete();
            m_pend = 0; m_hunt = 1; m_have_hi = 0; m_cnt = 0;
            m_fd = 0; m_ds = 0; m_ov = 0; m_uf = 0;
        end else begin
            size0  = mq.size();
            popped = rq && (size0 > 0);
            if (rq && size0 == 0) m_uf = 1;
            if (size0 >= START) m_ds = 1;
            if (popped) void'(mq.pop_front());
            if (m_pend) begin
                if (size0 < DEPTH || popped) mq.push_back(m_pend_pix);
                else m_ov = 1;
            end
            m_pend = 0;
            m_fd   = 0;
            if (rv) begin
                if (m_hunt) begin
                    if (rb == 8'hA5) begin
                        m_hunt    = 0;
                        m_have_hi = 0;
                    end
                end else if (!m_have_hi) begin
                    m_hi      = rb;
                    m_have_hi = 1;
                end else begin
                    m_pend     = 1;
                    m_pend_pix = {m_hi, rb};
                    m_have_hi  = 0;
                    m_cnt++;
                    if (m_cnt == FRAME) begin
                        m_fd   = 1;
                        m_cnt  = 0;
                        m_hunt = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_val("data_in",    32'(Data_in),    32'((mq.size() > 0) ? mq[0] : UC));
        check_val("fifo_level", 32'(Fifo_level), 32'(mq.size()));
        check_val("data_start", 32'(Data_start), 32'(m_ds));
        check_val("frame_done", 32'(Frame_done), 32'(m_fd));
        check_val("overflow",   32'(Overflow),   32'(m_ov));
        check_val("underflow",  32'(Underflow),  32'(m_uf));
    endtask

    task automatic step(input bit rst, input bit rv, input logic [7:0] rb, input bit rq);
        Reset    = rst;
        Rx_done  = rv;
        Rx_data  = rb;
        Data_req = rq;
        #1;
        check_outputs();
        @(posedge CLK_33M);
        model_edge(rst, rv, rb, rq);
        #1;
        if (Frame_done === 1'b1) fd_seen++;
    endtask

    task automatic send(input logic [7:0] b);
        step(0, 1, b, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 8'h00, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00, 0);
    endtask

    initial begin
        repeat (2) @(posedge CLK_33M);
        #1;
        model_edge(1, 0, 8'h00, 0);

        // 1: basic pixel assembly and FWFT read
        send(8'hA5); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        idle(2);
        check_val("t1_level", 32'(Fifo_level), 32'd2);
        check_val("t1_head", 32'(Data_in), 32'h1234);
        check_val("t1_start", 32'(Data_start), 32'd0);
        step(0, 0, 8'h00, 1);
        check_val("t1_after_pop", 32'(Data_in), 32'h5678);

        // 2: bytes before sync are discarded
        do_reset();
        send(8'h00); send(8'hFF); idle(2);
        check_val("t2_pre_sync", 32'(Fifo_level), 32'd0);
        send(8'hA5); idle(2);
        check_val("t2_sync_only", 32'(Fifo_level), 32'd0);
        send(8'h11); send(8'h22); idle(2);
        check_val("t2_level", 32'(Fifo_level), 32'd1);
        check_val("t2_head", 32'(Data_in), 32'h1122);

        // 3: frame end and return to sync hunt
        do_reset();
        fd_seen = 0;
        send(8'hA5);
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(2);
        check_val("t3_frame_done_cnt", 32'(fd_seen), 32'd1);
        check_val("t3_level", 32'(Fifo_level), 32'd4);
        send(8'h11); send(8'h22); idle(2);
        check_val("t3_no_sync_level", 32'(Fifo_level), 32'd4);
        check_val("t3_frame_done_cnt2", 32'(fd_seen), 32'd1);

        // 4: Data_start threshold and stickiness
        do_reset();
        send(8'hA5);
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
        idle(1);
        check_val("t4_level3", 32'(Fifo_level), 32'd3);
        check_val("t4_start_lag", 32'(Data_start), 32'd0);
        idle(1);
        check_val("t4_start_set", 32'(Data_start), 32'd1);
        repeat (3) step(0, 0, 8'h00, 1);
        check_val("t4_drained", 32'(Fifo_level), 32'd0);
        check_val("t4_start_sticky", 32'(Data_start), 32'd1);
        check_val("t4_no_underflow", 32'(Underflow), 32'd0);

        // 5: overflow drop, then full push with simultaneous pop
        do_reset();
        send(8'hA5);
        for (int i = 1; i <= 8; i++) send(8'(8'h20 + i));
        idle(2);
        check_val("t5_full", 32'(Fifo_level), 32'd4);
        check_val("t5_no_ovf", 32'(Overflow), 32'd0);
        send(8'hA5); send(8'h01); send(8'h02); idle(2);
        check_val("t5_ovf", 32'(Overflow), 32'd1);
        check_val("t5_level_drop", 32'(Fifo_level), 32'd4);
        send(8'h03); send(8'h04);
        step(0, 0, 8'h00, 1);
        idle(1);
        check_val("t5_level_pushpop", 32'(Fifo_level), 32'd4);

        // 6: underflow colour, then reset mid-frame
        do_reset();
        check_val("t6_under_color", 32'(Data_in), 32'hF81F);
        step(0, 0, 8'h00, 1);
        check_val("t6_underflow", 32'(Underflow), 32'd1);
        send(8'hA5); send(8'h12); send(8'h34); send(8'h56);
        do_reset();
        check_val("t6_rst_level", 32'(Fifo_level), 32'd0);
        check_val("t6_rst_data", 32'(Data_in), 32'hF81F);
        check_val("t6_rst_start", 32'(Data_start), 32'd0);
        check_val("t6_rst_fd", 32'(Frame_done), 32'd0);
        check_val("t6_rst_ovf", 32'(Overflow), 32'd0);
        check_val("t6_rst_udf", 32'(Underflow), 32'd0);
        send(8'h78); send(8'h9A); idle(2);
        check_val("t6_needs_sync", 32'(Fifo_level), 32'd0);

        // Random traffic, alternating light and heavy request load
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          rst;
            bit          rv;
            bit          rq;
            logic [7:0]  rb;
            rst = ($urandom_range(0, 599) == 0);
            rv  = ($urandom_range(0, 2) != 0);
            rb  = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
            if (((i / 300) % 2) == 0) rq = ($urandom_range(0, 3) == 0);
            else                      rq = ($urandom_range(0, 3) != 0);
            step(rst, rv, rb, rq);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
